sr_reg_file: RTL and testbench
==============================

// Module: sr_reg_file
// PURPOSE
//   Parametrised register file for the 16-bit CPU datapath.
//   Generalises the single gated set/reset storage bit to NUM_REGS words of WIDTH bits.
//   Each word supports four write operations: hold, load, bit-set and bit-clear.
//   One write port, two registered read ports; sits between the decoder/control unit and the ALU operand buses.
// PARAMETERS
//   WIDTH     16  bits per register word
//   NUM_REGS  8   number of registers; power of two, >= 2
//   AW        3   address width, = log2(NUM_REGS)
//   ZERO_REG  1   1: register 0 is hard-wired to zero and writes to it are rejected; 0: register 0 is ordinary
// PORTS
//   clk        in   1      single clock; all state changes on the rising edge
//   resetn     in   1      synchronous reset, active low
//   wr_op      in   2      00 hold, 01 load, 10 set-bits, 11 clear-bits
//   wr_addr    in   AW     target register of the write operation
//   wr_data    in   WIDTH  load value, or bit mask for set/clear
//   rd_addr_a  in   AW     read port A address
//   rd_addr_b  in   AW     read port B address
//   rd_data_a  out  WIDTH  registered read data, port A
//   rd_data_b  out  WIDTH  registered read data, port B
//   wr_reject  out  1      1-cycle pulse: the previous cycle's write targeted protected register 0
//   err_sticky out  1      set by any rejected write; cleared only by reset
// BEHAVIOUR
//   - Reset (resetn=0 at the clock edge):
//     - all registers 0; rd_data_a/b 0; wr_reject 0; err_sticky 0.
//     - Reset wins over a simultaneous write; no write takes effect that cycle.
//   - Write operations, applied at the edge to R = regs[wr_addr]:
//     - 00: R unchanged (hold).
//     - 01: R <= wr_data.
//     - 10: R <= R | wr_data (per-bit set).
//     - 11: R <= R & ~wr_data (per-bit clear).
//     - Mask bits that are 0 leave the corresponding bit unchanged; no carries or cross-bit effects.
//   - Protected register 0 (ZERO_REG=1):
//     - A write with wr_op != 00 and wr_addr = 0 is discarded; regs[0] stays 0.
//     - wr_reject = 1 in the next cycle only; err_sticky <= 1.
//     - With ZERO_REG=0, register 0 behaves like every other register and wr_reject/err_sticky stay 0.
//   - Reads:
//     - Registered, latency 1: rd_data_x at edge n+1 reflects rd_addr_x sampled at edge n.
//     - Ports A and B are independent and may use the same address.
//   - Read-during-write to the same address: see CONFIGURATION.
//   - Reset mid-stream:
//     - An in-flight read is lost; rd_data returns 0 the cycle after reset.
//     - The first valid read data appears one cycle after resetn rises.
// CONFIGURATION
//   - SR_REG_BYPASS_EN defined:
//     - When a read address equals wr_addr and the write is accepted (wr_op != 00, not rejected),
//       rd_data returns the post-write value computed for that operation (write-first).
//   - SR_REG_BYPASS_EN undefined:
//     - The same case returns the pre-write value (read-first); the new value is visible on the next read.
//   - Rejected writes and hold never bypass in either build.
// TESTING
//   1. Reset: hold resetn=0 for 2 cycles after random writes -> all rd_data 0, err_sticky 0;
//      reading every register after release returns 0.
//   2. Ops on R3, WIDTH=16: load 16'hA5A5 -> set-bits 16'h0F00 -> clear-bits 16'h0005 ->
//      reads give 16'hA5A5, 16'hAFA5, 16'hAFA0; hold leaves 16'hAFA0.
//   3. Protected R0 (ZERO_REG=1): load 16'hFFFF to R0 -> wr_reject pulses exactly 1 cycle,
//      err_sticky=1 until reset, R0 reads 16'h0000 on both ports.
//   4. Read-during-write: R5=16'h1111; in one cycle load 16'h2222 to R5 with rd_addr_a=rd_addr_b=5
//      -> rd_data=16'h2222 with SR_REG_BYPASS_EN, 16'h1111 without; next read 16'h2222 in both builds.
//   5. Port independence: rd_addr_a=1, rd_addr_b=7 each cycle while writing R2
//      -> both ports track R1/R7 with 1-cycle latency and are unaffected by the R2 writes.
//   6. Reset vs write: resetn=0 in the same cycle as a load of 16'h1234 to R4 -> R4 reads 0 after reset.

Source files
------------

// File: rtl/sr_reg_file.sv
// Register file with hold/load/bit-set/bit-clear writes, one write port and two registered read ports.
// Define SR_REG_BYPASS_EN to make a read of the register being written return the post-write value.
module sr_reg_file #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       wr_op,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             wr_reject,
  output logic             err_sticky
);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] new_val;
  logic [WIDTH-1:0] rd_next_a;
  logic [WIDTH-1:0] rd_next_b;
  logic             wr_active;
  logic             wr_rejected;
  logic             wr_accept;

  assign wr_active   = (wr_op != OP_HOLD);
  // Register 0 is never written when protected, so it keeps its reset value of zero.
  assign wr_rejected = (ZERO_REG != 0) && wr_active && (wr_addr == '0);
  assign wr_accept   = wr_active && !wr_rejected;

  always_comb begin
    cur_val = regs[wr_addr];
    new_val = cur_val;
    case (wr_op)
      OP_LOAD:  new_val = wr_data;
      OP_SET:   new_val = cur_val | wr_data;
      OP_CLEAR: new_val = cur_val & ~wr_data;
      default:  new_val = cur_val;
    endcase
  end

  always_comb begin
    rd_next_a = regs[rd_addr_a];
    rd_next_b = regs[rd_addr_b];
`ifdef SR_REG_BYPASS_EN
    // Write-first: forward the value this edge is about to store.
    if (wr_accept && (rd_addr_a == wr_addr)) rd_next_a = new_val;
    if (wr_accept && (rd_addr_b == wr_addr)) rd_next_b = new_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
      wr_reject  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (wr_accept) regs[wr_addr] <= new_val;
      rd_data_a  <= rd_next_a;
      rd_data_b  <= rd_next_b;
      wr_reject  <= wr_rejected;
      err_sticky <= err_sticky | wr_rejected;
    end
  end

endmodule

// File: tb/tb_sr_reg_file.sv
// Directed bench for sr_reg_file: reset, write ops, register-0 protection, read-during-write, port independence.
module tb_sr_reg_file;

  logic        clk;
  logic        resetn;
  logic [1:0]  wr_op;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        wr_reject;
  logic        err_sticky;

  int n_cmp = 0;
  int n_err = 0;

  sr_reg_file #(.WIDTH(16), .NUM_REGS(8), .AW(3), .ZERO_REG(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_op      (wr_op),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .wr_reject  (wr_reject),
    .err_sticky (err_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] op, input logic [2:0] addr, input logic [15:0] data);
    wr_op   = op;
    wr_addr = addr;
    wr_data = data;
  endtask

  logic [15:0] exp_rdw;

  initial begin
    resetn = 1'b0;
    wr(2'b00, 3'd0, 16'h0000);
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;

    // initial reset
    step();
    step();
    check("rst_rd_a", rd_data_a, 16'h0000);
    check("rst_rd_b", rd_data_b, 16'h0000);
    check("rst_reject", {15'd0, wr_reject}, 16'h0000);
    check("rst_sticky", {15'd0, err_sticky}, 16'h0000);

    // random writes (including a rejected one to R0), then reset for two cycles
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr(2'b01, 3'(i), 16'($urandom_range(1, 16'hFFFF)));
      step();
    end
    check("pre_rst_sticky", {15'd0, err_sticky}, 16'h0001);
    rd_addr_a = 3'd3;
    rd_addr_b = 3'd4;
    resetn = 1'b0;
    wr(2'b01, 3'd4, 16'h1234);
    step();
    check("rst1_rd_a", rd_data_a, 16'h0000);
    check("rst1_rd_b", rd_data_b, 16'h0000);
    wr(2'b00, 3'd0, 16'h0000);
    step();
    check("rst2_rd_a", rd_data_a, 16'h0000);
    check("rst2_rd_b", rd_data_b, 16'h0000);
    check("rst2_sticky", {15'd0, err_sticky}, 16'h0000);
    check("rst2_reject", {15'd0, wr_reject}, 16'h0000);

    // every register reads 0 after release (R4 also covers reset beating the load)
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      step();
      check($sformatf("post_rst_a%0d", i), rd_data_a, 16'h0000);
      check($sformatf("post_rst_b%0d", 7 - i), rd_data_b, 16'h0000);
    end

    // write operations on R3
    rd_addr_a = 3'd3;
    rd_addr_b = 3'd3;
    wr(2'b01, 3'd3, 16'hA5A5);
    step();
    wr(2'b00, 3'd0, 16'h0000);
    step();
    check("r3_load", rd_data_a, 16'hA5A5);
    wr(2'b10, 3'd3, 16'h0F00);
    step();
    wr(2'b00, 3'd0, 16'h0000);
    step();
    check("r3_set", rd_data_a, 16'hAFA5);
    wr(2'b11, 3'd3, 16'h0005);
    step();
    wr(2'b00, 3'd0, 16'h0000);
    step();
    check("r3_clear", rd_data_b, 16'hAFA0);
    wr(2'b00, 3'd3, 16'hFFFF);
    step();
    step();
    check("r3_hold", rd_data_a, 16'hAFA0);

    // protected R0
    wr(2'b01, 3'd0, 16'hFFFF);
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    step();
    check("r0_reject_pulse", {15'd0, wr_reject}, 16'h0001);
    check("r0_sticky_set", {15'd0, err_sticky}, 16'h0001);
    wr(2'b00, 3'd0, 16'h0000);
    step();
    check("r0_reject_end", {15'd0, wr_reject}, 16'h0000);
    check("r0_sticky_hold", {15'd0, err_sticky}, 16'h0001);
    check("r0_rd_a", rd_data_a, 16'h0000);
    check("r0_rd_b", rd_data_b, 16'h0000);
    step();
    check("r0_sticky_hold2", {15'd0, err_sticky}, 16'h0001);

    // read-during-write on R5
    wr(2'b01, 3'd5, 16'h1111);
    step();
    wr(2'b01, 3'd5, 16'h2222);
    rd_addr_a = 3'd5;
    rd_addr_b = 3'd5;
    step();
`ifdef SR_REG_BYPASS_EN
    exp_rdw = 16'h2222;
`else
    exp_rdw = 16'h1111;
`endif
    check("rdw_a", rd_data_a, exp_rdw);
    check("rdw_b", rd_data_b, exp_rdw);
    wr(2'b00, 3'd0, 16'h0000);
    step();
    check("rdw_next_a", rd_data_a, 16'h2222);
    check("rdw_next_b", rd_data_b, 16'h2222);

    // port independence while writing R2
    wr(2'b01, 3'd1, 16'h0101);
    step();
    wr(2'b01, 3'd7, 16'h0707);
    step();
    rd_addr_a = 3'd1;
    rd_addr_b = 3'd7;
    wr(2'b01, 3'd2, 16'h2222);
    step();
    check("ind_a0", rd_data_a, 16'h0101);
    check("ind_b0", rd_data_b, 16'h0707);
    wr(2'b10, 3'd2, 16'h0008);
    step();
    check("ind_a1", rd_data_a, 16'h0101);
    check("ind_b1", rd_data_b, 16'h0707);
    wr(2'b11, 3'd2, 16'h0002);
    step();
    check("ind_a2", rd_data_a, 16'h0101);
    check("ind_b2", rd_data_b, 16'h0707);
    wr(2'b00, 3'd0, 16'h0000);
    rd_addr_a = 3'd2;
    step();
    check("ind_r2", rd_data_a, 16'h2228);
    check("ind_b3", rd_data_b, 16'h0707);

    // reset clears the sticky flag
    resetn = 1'b0;
    step();
    check("final_sticky", {15'd0, err_sticky}, 16'h0000);
    check("final_rd_a", rd_data_a, 16'h0000);
    resetn = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
